// File: rtl/pkg_deserializer_pkg.sv
// Types shared by the byte-serial transmitter and the deserializer:
// one frame is four bytes sent a, b, c, d.
package pkg_deserializer_pkg;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } pkg_t;

    // The first three beats arrive oldest-first in the top of the shift word.
    function automatic pkg_t pack_beats(input logic [23:0] head, input logic [7:0] last);
        pkg_t p;
        p = {head, last};
        return p;
    endfunction

endpackage

// File: rtl/pkg_deserializer_word_fifo.sv
// Small synchronous FIFO of DEPTH words (power of two); pointers wrap
// naturally and the count carries one extra bit to tell full from empty.
module word_fifo
    import pkg_deserializer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type T = pkg_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    output T                         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pkg_deserializer.sv
// Collects four consecutive put beats into one pkg_t word and queues it
// for a valid/ready consumer; broken or refused frames raise err.
module pkg_deserializer
    import pkg_deserializer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               payload,
    input  logic                     put,
    output logic                     free,
    output pkg_t                     value,
    output logic                     valid,
    input  logic                     ready,
    output logic                     err,
    output logic [1:0]               dbg_state_o,
    output logic [$clog2(DEPTH):0]   dbg_count_o
);

    // Consumer handshake: a word transfers on every rising edge where
    // valid && ready; value is held steady while valid && !ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [23:0]   shift_q, shift_d;
    logic          err_q, err_d;
    logic          push;
    pkg_t          push_word;
    pkg_t          head;
    logic          empty;
    logic          full;

    assign free        = (state_q == IDLE) && !full;
    assign valid       = !empty;
    assign value       = valid ? head : '0;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        err_d     = 1'b0;
        push      = 1'b0;
        push_word = pack_beats(shift_q, payload);
        case (state_q)
            IDLE: begin
                if (put) begin
                    if (free) begin
                        state_d = B1;
                        shift_d = {shift_q[15:0], payload};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            B1, B2: begin
                if (put) begin
                    state_d = (state_q == B1) ? B2 : B3;
                    shift_d = {shift_q[15:0], payload};
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            B3: begin
                state_d = IDLE;
                if (put) begin
                    push = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            err_q   <= err_d;
        end
    end

    // A frame only starts with room in the FIFO, so push never meets full.
    word_fifo #(
        .DEPTH (DEPTH),
        .T     (pkg_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (ready),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full),
        .count_o (dbg_count_o)
    );

endmodule

// File: tb/tb_pkg_deserializer.sv
// Directed bench for pkg_deserializer with a queue-based frame model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_pkg_deserializer;
    import pkg_deserializer_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  payload;
    logic        put;
    logic        free;
    pkg_t        value;
    logic        valid;
    logic        ready;
    logic        err;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_count;

    int n_vec;
    int n_fail;

    pkg_deserializer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .payload     (payload),
        .put         (put),
        .free        (free),
        .value       (value),
        .valid       (valid),
        .ready       (ready),
        .err         (err),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: bytes of the frame in progress and words waiting for the consumer.
    logic [7:0]  part_q[$];
    logic [31:0] exp_q[$];
    logic        m_err;
    logic        m_err_n;
    bit          m_was_full;
    bit          m_pop;
    bit          m_done;
    logic [31:0] m_word;

    initial begin
        m_err = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                part_q.delete();
                exp_q.delete();
                m_err = 1'b0;
            end else begin
                m_was_full = (exp_q.size() >= DEPTH);
                m_pop      = ready && (exp_q.size() > 0);
                m_done     = 1'b0;
                m_err_n    = 1'b0;
                m_word     = '0;
                if (put) begin
                    if (part_q.size() == 0 && m_was_full) begin
                        m_err_n = 1'b1;
                    end else begin
                        part_q.push_back(payload);
                        if (part_q.size() == 4) begin
                            m_word = {part_q[0], part_q[1], part_q[2], part_q[3]};
                            m_done = 1'b1;
                            part_q.delete();
                        end
                    end
                end else if (part_q.size() != 0) begin
                    part_q.delete();
                    m_err_n = 1'b1;
                end
                if (m_pop) void'(exp_q.pop_front());
                if (m_done) exp_q.push_back(m_word);
                m_err = m_err_n;
            end
        end
    end

    logic [31:0] e_valid, e_value, e_free, e_state, e_count;

    initial begin
        forever begin
            @(negedge clk);
            e_valid = (exp_q.size() > 0) ? 32'd1 : 32'd0;
            e_value = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
            e_free  = (part_q.size() == 0 && exp_q.size() < DEPTH) ? 32'd1 : 32'd0;
            e_state = 32'(part_q.size());
            e_count = 32'(exp_q.size());
            check("cyc_valid", 32'(valid), e_valid);
            check("cyc_value", value, e_value);
            check("cyc_free", 32'(free), e_free);
            check("cyc_err", 32'(err), 32'(m_err));
            check("cyc_state", 32'(dbg_state), e_state);
            check("cyc_count", 32'(dbg_count), e_count);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic beat(input logic [7:0] b);
        @(posedge clk);
        #2;
        put     = 1'b1;
        payload = b;
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        put = 1'b0;
    endtask

    task automatic send_beats(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            beat(w[31-8*i -: 8]);
        end
    endtask

    // Requires an empty FIFO and ready=1 beforehand.
    task automatic frame_and_check(input logic [31:0] w, input string nm);
        send_beats(w, 4);
        idle();
        check({nm, "_valid"}, 32'(valid), 32'd1);
        check({nm, "_value"}, value, w);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_vec   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        put     = 1'b0;
        payload = 8'h00;
        ready   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_free", 32'(free), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_value", value, 32'h0);
        rst_n = 1'b1;
        ready = 1'b1;
        idle();

        // single frame
        frame_and_check(32'h0001023F, "single");
        idle();
        check("single_drop", 32'(valid), 32'd0);

        // fill and backpressure
        ready = 1'b0;
        send_beats(32'hDEADBEEF, 4);
        idle();
        send_beats(32'h12345678, 4);
        idle();
        check("fill_free", 32'(free), 32'd0);
        check("fill_count", 32'(dbg_count), 32'd2);
        check("fill_head", value, 32'hDEADBEEF);
        beat(8'h99);
        idle();
        check("full_err", 32'(err), 32'd1);
        check("full_count", 32'(dbg_count), 32'd2);
        check("full_state", 32'(dbg_state), 32'd0);
        idle();
        check("full_err_clear", 32'(err), 32'd0);
        ready = 1'b1;
        check("pop1_value", value, 32'hDEADBEEF);
        idle();
        check("pop2_value", value, 32'h12345678);
        idle();
        check("pop_empty", 32'(valid), 32'd0);

        // aborted frame
        beat(8'hAA);
        beat(8'hBB);
        idle();
        idle();
        check("abort_err", 32'(err), 32'd1);
        check("abort_state", 32'(dbg_state), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        frame_and_check(32'hCAFEF00D, "after_abort");

        // back-to-back frames, one idle cycle apart
        frame_and_check(32'h0F1E2D3C, "b2b0");
        check("b2b0_count", 32'(dbg_count), 32'd1);
        frame_and_check(32'h4B5A6978, "b2b1");
        check("b2b1_count", 32'(dbg_count), 32'd1);
        frame_and_check(32'h8796A5B4, "b2b2");
        check("b2b2_err", 32'(err), 32'd0);
        idle();

        // reset in the middle of a frame
        beat(8'h11);
        beat(8'h22);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        put   = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_free", 32'(free), 32'd1);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("post_rst_valid", 32'(valid), 32'd0);
        check("post_rst_free", 32'(free), 32'd1);
        frame_and_check(32'h55667788, "after_rst");
        idle();

        // push and pop on the same edge
        ready = 1'b0;
        send_beats(32'h0A0B0C0D, 4);
        idle();
        check("sim_pre_count", 32'(dbg_count), 32'd1);
        send_beats(32'h01020304, 3);
        @(posedge clk);
        #2;
        put     = 1'b1;
        payload = 8'h04;
        ready   = 1'b1;
        check("sim_pre_valid", 32'(valid), 32'd1);
        idle();
        check("sim_count", 32'(dbg_count), 32'd1);
        check("sim_valid", 32'(valid), 32'd1);
        check("sim_value", value, 32'h01020304);
        idle();
        check("sim_drain", 32'(valid), 32'd0);

        repeat (3) idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pkg_deserializer.md
PKG_DESERIALIZER -- requirements
Module: pkg_deserializer

Interface
REQ-001 Parameter: DEPTH, default 2, output FIFO depth in words (power of two, at least 2).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: payload  input  8  byte lane from the byte-serial transmitter.
REQ-005 Port: put  input  1  payload valid; high for exactly 4 consecutive cycles per frame.
REQ-006 Port: free  output  1  ready to accept a new frame; the transmitter samples it before its first beat.
REQ-007 Port: value  output  32 (pkg)  head-of-FIFO word; bytes {a,b,c,d}.
REQ-008 Port: valid  output  1  value holds an unread word.
REQ-009 Port: ready  input  1  consumer accepts value when valid and ready are both high.
REQ-010 Port: err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-011 Beat order SHALL be a, b, c, d; the first byte lands in value[31:24] and the last in value[7:0].
REQ-012 The FSM SHALL have states IDLE, B1, B2, B3: IDLE->B1 on put&&free; B1->B2->B3 on put; B3->IDLE on put (frame complete).
REQ-013 free SHALL be high only when state==IDLE and FIFO count<DEPTH; it is decoded from registered state only.
REQ-014 Beats 0-2 SHALL be captured in a 24-bit shift register; on the beat-3 edge, {shift,payload} SHALL be written to the FIFO directly.
REQ-015 Latency: valid SHALL rise in the cycle after the edge that samples beat 3; value is stable while valid && !ready.
REQ-016 Pop on valid&&ready; simultaneous push and pop leaves count unchanged, and data order is preserved.
REQ-017 Back-to-back frames SHALL be accepted: put may go high in the cycle state returns to IDLE if free is high.
REQ-018 put low in B1/B2/B3: the partial frame is discarded, the FSM returns to IDLE, err pulses, and the FIFO is untouched.
REQ-019 put high in IDLE while free is low (FIFO full): the byte is ignored, the FSM stays in IDLE, and err pulses.
REQ-020 The FIFO SHALL never be written when full; pop when empty SHALL be ignored.
REQ-021 FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-022 On rst_n low, the following take effect immediately regardless of clk: state=IDLE, count=0, pointers=0, shift register=0.
REQ-023 Output values during reset: valid=0, err=0, free=1, value=32'h0.
REQ-024 Reset mid-frame SHALL discard the partial frame and all FIFO contents; no err is raised for it.
REQ-025 Reset release SHALL be synchronised externally; the block needs no internal synchroniser.

Structure
REQ-026 The pkg struct (a,b,c,d each 8 bits) SHALL be defined once in a shared package, used by this block and the byte-serial transmitter.
REQ-027 FIFO storage, pointers and count SHALL be a sub-module word_fifo, parameterised by DEPTH and element type pkg.
REQ-028 The FSM state enum SHALL be local to pkg_deserializer, not in the package.

Verification
REQ-029 Single frame:
- Stimulus: after reset, bytes 8'h00, 8'h01, 8'h02, 8'h3F with put high for 4 cycles and ready=1.
- Response: valid pulses one cycle with value=32'h0001023F, one cycle after the 4th beat.
REQ-030 Fill and backpressure:
- Stimulus: ready=0; send frames 32'hDEADBEEF then 32'h12345678.
- Response: free low after the 2nd frame; a 3rd put in IDLE gives an err pulse and the FIFO is unchanged.
- Then raise ready: the words pop in order DEADBEEF, 12345678.
REQ-031 Aborted frame:
- Stimulus: put high 2 cycles (8'hAA, 8'hBB), then low.
- Response: err pulses once, state returns to IDLE, no valid; the next full frame 32'hCAFEF00D is received intact.
REQ-032 Back-to-back:
- Stimulus: 3 frames with one IDLE cycle between them, ready=1.
- Response: 3 words in order, no err, count never exceeds 1.
REQ-033 Reset mid-frame:
- Stimulus: rst_n low after beat 2 of 32'h11223344.
- Response: after release, valid=0 and free=1; the next frame 32'h55667788 is received correctly.
REQ-034 Simultaneous push and pop:
- Stimulus: FIFO holds 1 word and ready=1 on the beat-3 edge.
- Response: count stays 1 and valid stays high across the edge.
